mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_unit_mult.sv | 26 ++
 rtl/mul_unit.sv | 92 +++++++++
 tb/tb_mul_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the pipelined multiplier: op encoding
// and the op -> operand signedness decode.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  // Returns {a_signed, b_signed}.
  function automatic logic [1:0] mul_decode(input mul_op_e op);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      MUL:     r = 2'b00;
      MULH:    r = 2'b11;
      MULHSU:  r = 2'b10;
      MULHU:   r = 2'b00;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_unit_mult.sv
// Combinational p_width x p_width multiplier with per-operand
// signedness. Ports: a_i, b_i, a_signed_i, b_signed_i -> product_o.
module mul_unit_mult #(
  parameter int p_width = 32
) (
  input  logic [p_width-1:0]   a_i,
  input  logic [p_width-1:0]   b_i,
  input  logic                 a_signed_i,
  input  logic                 b_signed_i,
  output logic [2*p_width-1:0] product_o
);

  logic             w_a_ext;
  logic             w_b_ext;
  logic [2*p_width-1:0] w_a;
  logic [2*p_width-1:0] w_b;

  // Extending both operands to the full product width makes a
  // plain modulo-2^(2w) multiply give the correct mixed-sign result.
  assign w_a_ext   = a_signed_i & a_i[p_width-1];
  assign w_b_ext   = b_signed_i & b_i[p_width-1];
  assign w_a       = {{p_width{w_a_ext}}, a_i};
  assign w_b       = {{p_width{w_b_ext}}, b_i};
  assign product_o = w_a * w_b;

endmodule

// File: rtl/mul_unit.sv
// Two-stage valid/ready multiplier (MUL/MULH/MULHSU/MULHU).
// Ports: clk_i, rst_ni, valid_i/ready_o/a_i/b_i/op_i in, valid_o/ready_i/result_o out.
module mul_unit
  import mul_pkg::*;
#(
  parameter int p_width = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [p_width-1:0] a_i,
  input  logic [p_width-1:0] b_i,
  input  logic [1:0]         op_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [p_width-1:0] result_o
);

  logic               r_s1_valid;
  logic [p_width-1:0] r_s1_a;
  logic [p_width-1:0] r_s1_b;
  logic               r_s1_as;
  logic               r_s1_bs;
  mul_op_e            r_s1_op;

  logic               r_s2_valid;
  logic [p_width-1:0] r_s2_result;

  mul_op_e              w_op;
  logic [1:0]           w_sign;
  logic                 w_s2_load;
  logic [2*p_width-1:0] w_product;
  logic [p_width-1:0]   w_sel;

  assign w_op   = mul_op_e'(op_i);
  assign w_sign = mul_decode(w_op);

  // S2 frees up either by being empty or by handing its result out;
  // S1 may then take a new op in the same edge it advances.
  assign w_s2_load = !r_s2_valid || ready_i;
  assign ready_o   = !r_s1_valid || w_s2_load;

  mul_unit_mult #(
    .p_width(p_width)
  ) u_mult (
    .a_i       (r_s1_a),
    .b_i       (r_s1_b),
    .a_signed_i(r_s1_as),
    .b_signed_i(r_s1_bs),
    .product_o (w_product)
  );

  assign w_sel = (r_s1_op == MUL) ? w_product[p_width-1:0]
                                  : w_product[2*p_width-1:p_width];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_as    <= 1'b0;
      r_s1_bs    <= 1'b0;
      r_s1_op    <= MUL;
    end else if (ready_o) begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_s1_a  <= a_i;
        r_s1_b  <= b_i;
        r_s1_as <= w_sign[1];
        r_s1_bs <= w_sign[0];
        r_s1_op <= w_op;
      end
    end
  end

  // The result register is forced to zero when empty so the
  // output bus is quiet whenever valid_o is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
    end else if (w_s2_load) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_result <= r_s1_valid ? w_sel : '0;
    end
  end

  assign valid_o  = r_s2_valid;
  assign result_o = r_s2_result;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit at p_width=4: directed per-op,
// corner, back-pressure, streaming, reset and randomized exhaustive runs.
module tb_mul_unit;

  logic       clk;
  logic       rst_ni;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic [1:0] op_i;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] result_o;

  int checks;
  int failures;
  int cyc;
  int n_out;

  typedef struct {
    logic [3:0] res;
    int         acc;
  } exp_t;

  exp_t q[$];
  bit   vhist[int];

  mul_unit #(.p_width(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: sign-extend to 5 bits, multiply, pick a half.
  function automatic logic [3:0] ref_mul(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [1:0] op);
    int ea;
    int eb;
    logic [7:0] p;
    bit sa;
    bit sb;
    sa = (op == 2'd1) || (op == 2'd2);
    sb = (op == 2'd1);
    ea = (sa && a[3]) ? int'(a) - 16 : int'(a);
    eb = (sb && b[3]) ? int'(b) - 16 : int'(b);
    p  = 8'(ea * eb);
    return (op == 2'd0) ? p[3:0] : p[7:4];
  endfunction

  // Every cycle: the oldest in-flight op must be on the output
  // from two cycles after acceptance until it is taken.
  always @(negedge clk) begin
    bit exp_v;
    bit exp_r;
    if (!rst_ni) begin
      q.delete();
    end else begin
      exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
      exp_r = !((q.size() == 2) && !ready_i);
      vhist[cyc] = valid_o;
      check("mon_valid_o", valid_o, exp_v);
      check("mon_ready_o", ready_o, exp_r);
      if (!exp_v)
        check("mon_result_idle", result_o, 0);
      else
        check("mon_result", result_o, q[0].res);
      if (exp_v && valid_o && ready_i) begin
        void'(q.pop_front());
        n_out++;
      end
      if (valid_i && ready_o)
        q.push_back('{res: ref_mul(a_i, b_i, op_i), acc: cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (5) step();
  endtask

  task automatic run_one(input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [3:0] exp,
                         input string nm);
    int acc;
    int n;
    drain();
    a_i = a;
    b_i = b;
    op_i = op;
    valid_i = 1'b1;
    acc = -1;
    n = 0;
    while (acc < 0 && n < 20) begin
      @(negedge clk);
      if (ready_o) acc = cyc;
      step();
      n++;
    end
    valid_i = 1'b0;
    a_i = 4'($urandom);
    b_i = 4'($urandom);
    check({nm, "_accepted"}, acc >= 0, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o && n < 10);
    check({nm, "_latency"}, cyc - acc, 2);
    check({nm, "_result"}, result_o, exp);
    step();
  endtask

  initial begin
    bit acc_bp[3];
    logic [3:0] hold_r;
    int out0;
    int acc0;
    int run;
    int idx;
    int ncyc;

    checks = 0;
    failures = 0;
    n_out = 0;
    rst_ni = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    op_i = '0;
    repeat (3) step();
    rst_ni = 1'b1;
    @(negedge clk);
    check("reset_valid_o", valid_o, 0);
    check("reset_ready_o", ready_o, 1);
    check("reset_result_o", result_o, 0);
    step();

    check("pin_mul_f2", ref_mul(4'hF, 4'h2, 2'd0), 4'hE);
    check("pin_mulh_f2", ref_mul(4'hF, 4'h2, 2'd1), 4'hF);
    check("pin_mulhsu_f2", ref_mul(4'hF, 4'h2, 2'd2), 4'hF);
    check("pin_mulhu_f2", ref_mul(4'hF, 4'h2, 2'd3), 4'h1);
    check("pin_mulhsu_88", ref_mul(4'h8, 4'h8, 2'd2), 4'hC);

    run_one(4'hF, 4'h2, 2'd0, 4'hE, "mul_f2");
    run_one(4'hF, 4'h2, 2'd1, 4'hF, "mulh_f2");
    run_one(4'hF, 4'h2, 2'd2, 4'hF, "mulhsu_f2");
    run_one(4'hF, 4'h2, 2'd3, 4'h1, "mulhu_f2");
    run_one(4'h8, 4'h8, 2'd1, 4'h4, "mulh_88");
    run_one(4'h8, 4'h8, 2'd3, 4'h4, "mulhu_88");
    run_one(4'h8, 4'h8, 2'd2, 4'hC, "mulhsu_88");
    run_one(4'h8, 4'h8, 2'd0, 4'h0, "mul_88");

    // Back-pressure: three offers against a stalled consumer.
    drain();
    ready_i = 1'b0;
    out0 = n_out;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      a_i = 4'(i + 1);
      b_i = 4'h3;
      op_i = 2'd0;
      @(negedge clk);
      acc_bp[i] = ready_o;
      step();
    end
    check("bp_accept0", acc_bp[0], 1);
    check("bp_accept1", acc_bp[1], 1);
    check("bp_accept2", acc_bp[2], 0);
    @(negedge clk);
    hold_r = result_o;
    check("bp_stall_valid", valid_o, 1);
    repeat (2) step();
    @(negedge clk);
    check("bp_stall_hold", result_o, hold_r);
    check("bp_stall_ready", ready_o, 0);
    valid_i = 1'b0;
    step();
    ready_i = 1'b1;
    repeat (5) step();
    check("bp_outputs", n_out - out0, 2);

    // Streaming: 16 back-to-back ops.
    drain();
    acc0 = -1;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1;
      a_i = 4'($urandom);
      b_i = 4'($urandom);
      op_i = 2'($urandom);
      @(negedge clk);
      if (acc0 < 0 && ready_o) acc0 = cyc;
      step();
    end
    valid_i = 1'b0;
    repeat (5) step();
    run = 0;
    for (int j = 0; j < 20; j++) begin
      if (vhist.exists(acc0 + 2 + j) && vhist[acc0 + 2 + j] && run == j)
        run++;
    end
    check("stream_run", run, 16);
    check("stream_pre", vhist.exists(acc0 + 1) ? vhist[acc0 + 1] : 1'b1, 0);

    // Reset with both stages full and a new op on the input.
    drain();
    ready_i = 1'b0;
    out0 = n_out;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1;
      a_i = 4'h7;
      b_i = 4'(i + 5);
      op_i = 2'd0;
      step();
    end
    a_i = 4'h9;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("rst_valid_o", valid_o, 0);
    check("rst_ready_o", ready_o, 1);
    check("rst_result_o", result_o, 0);
    step();
    repeat (8) step();
    check("rst_no_stale", n_out - out0, 0);

    // All ops x all a x all b, random valid/ready.
    drain();
    out0 = n_out;
    idx = 0;
    ncyc = 0;
    while (idx < 1024 && ncyc < 20000) begin
      logic [9:0] v;
      ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(3) != 0) begin
        v = 10'(idx);
        valid_i = 1'b1;
        op_i = v[9:8];
        a_i = v[7:4];
        b_i = v[3:0];
      end else begin
        valid_i = 1'b0;
        op_i = 2'($urandom);
        a_i = 4'($urandom);
        b_i = 4'($urandom);
      end
      @(negedge clk);
      if (valid_i && ready_o) idx++;
      step();
      ncyc++;
    end
    valid_i = 1'b0;
    check("exh_accepted", idx, 1024);
    drain();
    check("exh_outputs", n_out - out0, 1024);
    check("exh_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
